// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared constants and state type for the multdiv unit
package multdiv_pkg;

    // Operand/result width; the divider performs one iteration per bit.
    localparam int WIDTH = 32;

    // Clocks from the start edge to the edge that raises data_resultRDY.
    localparam int DIV_LATENCY = 34;

    // Iteration counter width; terminal count is WIDTH-1.
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_e;

endpackage

// File: rtl/negate32.sv
// rtl/negate32.sv - two's-complement negation built from the inverter plus an incrementer
module negate32
    import multdiv_pkg::*;
(
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);

    logic [WIDTH-1:0] inv;

    not32 u_not (
        .in_i  (in_i),
        .out_o (inv)
    );

    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    assign out_o = inv + WIDTH'(1);

endmodule

// File: rtl/not32.sv
// rtl/not32.sv - 32-bit bitwise inverter stage
module not32
    import multdiv_pkg::*;
(
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);

    assign out_o = ~in_i;

endmodule

// File: rtl/div32_iter.sv
// rtl/div32_iter.sv - iterative 32-bit signed restoring divider with fixed latency
module div32_iter
    import multdiv_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] mag_b_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic             sign_q;
    logic             zero_q;
    logic [WIDTH-1:0] fix_res_q;
    logic             fix_exc_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;
    logic             rdy_q;
    logic             busy_q;

    logic [WIDTH-1:0] neg_a;
    logic [WIDTH-1:0] neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] inv_mag_b;
    logic [WIDTH-1:0] neg_quo;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] fix_res_d;

    negate32 u_neg_a (
        .in_i  (data_operandA),
        .out_o (neg_a)
    );

    negate32 u_neg_b (
        .in_i  (data_operandB),
        .out_o (neg_b)
    );

    negate32 u_neg_quo (
        .in_i  (quo_q),
        .out_o (neg_quo)
    );

    // The trial subtract adds the inverted divisor magnitude with a carry-in of one.
    not32 u_not_b (
        .in_i  (mag_b_q),
        .out_o (inv_mag_b)
    );

    // Operand magnitudes, one restoring step, and the sign-corrected quotient.
    always_comb begin
        mag_a     = data_operandA[WIDTH-1] ? neg_a : data_operandA;
        mag_b     = data_operandB[WIDTH-1] ? neg_b : data_operandB;
        // The remainder stays below |B| <= 2^31, so the shifted value fits in 32 bits
        // and a 33-bit signed trial never loses its sign.
        rem_sh    = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_sh + {1'b1, inv_mag_b} + {{WIDTH{1'b0}}, 1'b1};
        rem_d     = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        fix_res_d = zero_q ? '0 : (sign_q ? neg_quo : quo_q);
    end

    // Control FSM and datapath registers; a start pulse always restarts the operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mag_b_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
            fix_res_q <= '0;
            fix_exc_q <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (ctrl_DIV) begin
                mag_b_q <= mag_b;
                rem_q   <= '0;
                quo_q   <= mag_a;
                sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                zero_q  <= (data_operandB == '0);
                cnt_q   <= '0;
                state_q <= RUN;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        busy_q <= 1'b0;
                    end
                    RUN: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= FIX;
                        end
                    end
                    FIX: begin
                        fix_res_q <= fix_res_d;
                        fix_exc_q <= zero_q;
                        state_q   <= DONE;
                    end
                    DONE: begin
                        // busy stays high through the RDY cycle and drops in IDLE.
                        result_q <= fix_res_q;
                        exc_q    <= fix_exc_q;
                        rdy_q    <= 1'b1;
                        state_q  <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_div32_iter.sv
// tb/tb_div32_iter.sv - scoreboard bench for div32_iter
module tb_div32_iter;
    import multdiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          start;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] last_res = '0;
    logic        last_exc = 1'b0;

    div32_iter dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: signed quotient truncated toward zero, computed in 64-bit arithmetic.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int start);
        exp_t   e;
        longint q;
        e.start = start;
        if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
        end else begin
            q     = longint'($signed(a)) / longint'($signed(b));
            e.res = q[31:0];
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Issue one op at a negedge; an op still in flight before its RDY cycle is aborted.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        if (sb.size() > 0 && cyc < sb[$].start + DIV_LATENCY) begin
            void'(sb.pop_back());
        end
        sb.push_back(model(a, b, cyc + 1));
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_rdy_cycle();
        int n;
        n = sb[$].start + DIV_LATENCY - cyc;
        if (n > 0) repeat (n) @(negedge clock);
    endtask

    function automatic logic [31:0] rand_a();
        int r = $urandom_range(0, 9);
        if (r == 0) return 32'h8000_0000;
        if (r == 1) return 32'($urandom_range(0, 300)) - 32'd150;
        return $urandom;
    endfunction

    function automatic logic [31:0] rand_b();
        int r = $urandom_range(0, 9);
        if (r == 0) return 32'd0;
        if (r == 1) return 32'hFFFF_FFFF;
        if (r == 2) return 32'h8000_0000;
        if (r <= 4) return 32'($urandom_range(1, 40)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1);
        return $urandom;
    endfunction

    // Monitor: every RDY pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && data_resultRDY) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stray_rdy actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("result", data_result, e.res);
                chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
                chk("latency", 32'(cyc - e.start), 32'(DIV_LATENCY));
                chk("busy_at_rdy", {31'd0, busy}, 32'd1);
                last_res = e.res;
                last_exc = e.exc;
            end
        end
    end

    initial begin
        int mode;
        repeat (3) @(negedge clock);
        chk("reset_result", data_result, 32'd0);
        chk("reset_exc", {31'd0, data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        issue(32'd100, 32'd7);
        wait_done();
        chk("dir_100_7", data_result, 32'd14);
        issue(32'hFFFF_FF9C, 32'd7);
        wait_done();
        chk("dir_m100_7", data_result, 32'hFFFF_FFF2);
        issue(32'hFFFF_FF9C, 32'hFFFF_FFF9);
        wait_done();
        chk("dir_m100_m7", data_result, 32'd14);
        issue(32'd7, 32'd0);
        wait_done();
        chk("dir_div0_res", data_result, 32'd0);
        chk("dir_div0_exc", {31'd0, data_exception}, 32'd1);
        issue(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
        chk("dir_overflow", data_result, 32'h8000_0000);
        chk("dir_overflow_exc", {31'd0, data_exception}, 32'd0);

        // Restart mid-operation: only the second op may complete.
        issue(32'd100, 32'd7);
        repeat (9) @(negedge clock);
        issue(32'd50, 32'd5);
        wait_done();
        chk("abort_result", data_result, 32'd10);

        // Back-to-back: new start in the RDY cycle of the previous op.
        issue(32'd1000, 32'd9);
        wait_rdy_cycle();
        issue(32'hFFFF_FC18, 32'd3);
        wait_done();

        // Reset mid-operation, asserted together with a start pulse.
        issue(32'd100, 32'd7);
        repeat (19) @(negedge clock);
        reset         = 1'b1;
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd3;
        sb.delete();
        @(negedge clock);
        reset    = 1'b0;
        ctrl_DIV = 1'b0;
        chk("midreset_result", data_result, 32'd0);
        chk("midreset_exc", {31'd0, data_exception}, 32'd0);
        chk("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clock);
        chk("idle_after_reset_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 2);
            issue(rand_a(), rand_b());
            if (mode == 0) begin
                wait_done();
                repeat ($urandom_range(0, 3)) @(negedge clock);
            end else if (mode == 1) begin
                wait_rdy_cycle();
            end else begin
                repeat ($urandom_range(1, 34)) @(negedge clock);
            end
        end
        wait_done();

        repeat (6) @(negedge clock);
        chk("hold_result", data_result, last_res);
        chk("hold_exc", {31'd0, data_exception}, {31'd0, last_exc});
        chk("final_busy", {31'd0, busy}, 32'd0);
        chk("final_rdy", {31'd0, data_resultRDY}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div32_iter.md
# div32_iter

Iterative 32-bit signed integer divider for the multdiv unit. It consumes the bitwise-inverted operands produced by the existing 32-bit inverter stage (two's-complement negation = invert + 1) to form magnitudes and to sign-correct the quotient. The quotient is produced over a fixed multicycle latency. It sits between the ALU operand latch and the multdiv result mux, alongside the multiplier.

## Interface
- `WIDTH`, 32, operand/result width; the iteration count equals `WIDTH`.
- `clock`  in  1  single rising-edge clock.
- `reset`  in  1  synchronous, active-high; sampled on `clock` rising edge.
- `ctrl_DIV`  in  1  start pulse; operands sampled on the same edge.
- `data_operandA`  in  32  signed dividend.
- `data_operandB`  in  32  signed divisor.
- `data_result`  out  32  signed quotient, truncated toward zero.
- `data_exception`  out  1  divide-by-zero flag, valid with `data_resultRDY`.
- `data_resultRDY`  out  1  one-cycle done pulse.
- `busy`  out  1  high from the cycle after start until the cycle `data_resultRDY` is high, inclusive.

## Operation
- States:
  - IDLE.
  - RUN: counter 0..31.
  - FIX.
  - DONE.
- IDLE + `ctrl_DIV`=1:
  - latch |A|, |B|, sign_q = A[31]^B[31], and zero_div = (B==0).
  - Magnitude = operand if non-negative, else inverter output + 1.
  - Go to RUN, count=0.
- RUN: one restoring step per cycle.
  - {R,Q} shifted left 1; trial = R - |B|, computed as R + ~|B| + 1 using the inverter.
  - If trial is non-negative: R=trial, Q[0]=1; else Q[0]=0.
  - After count=31, go to FIX.
- FIX:
  - Quotient = Q if sign_q=0, else ~Q+1.
  - If zero_div: quotient forced to 0 and exception=1.
  - Go to DONE.
- DONE:
  - Register the quotient onto `data_result` and the flag onto `data_exception`.
  - Assert `data_resultRDY` for this cycle only; return to IDLE.
- Remainder is computed internally but not exported.
- Overflow case 0x80000000 / 0xFFFFFFFF wraps to 0x80000000 with no exception.
  - |0x80000000| is held as 0x80000000 unsigned; the datapath is 33 bits internally to avoid losing the sign.
- `ctrl_DIV`=1 while busy: abort the current op, re-latch the new operands, restart RUN at count=0. No `data_resultRDY` is issued for the aborted op.
- `data_result` and `data_exception` hold their last values until the next DONE.

## Timing
- `reset`=1 at an edge:
  - state goes to IDLE and the counter to 0.
  - `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0.
  - Reset overrides a simultaneous `ctrl_DIV`.
- Start sampled at edge E0. RUN occupies E1..E32, FIX E33, DONE E34.
  - `data_resultRDY`=1 for exactly the cycle following E34, i.e. latency is 34 clocks.
- The latency is fixed and identical for divide-by-zero.
- `ctrl_DIV` in the same cycle as `data_resultRDY`=1 is accepted: the new op starts, and the RDY pulse for the finished op still completes.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `multdiv_pkg`:
  - `WIDTH` constant.
  - state enum {IDLE, RUN, FIX, DONE}.
  - `DIV_LATENCY`=34 constant, used by both RTL and bench.
- One sub-module: `negate32` (`not32` followed by +1 incrementer). It is instantiated for:
  - operand A magnitude.
  - operand B magnitude.
  - quotient sign fix.
- The trial subtract reuses `not32` on |B|, with carry-in 1.
- Counter is 5 bits; terminal detect at 31.

## Test plan
- A=100, B=7, pulse `ctrl_DIV` → after 34 clocks `data_result`=14, `data_exception`=0, RDY high for 1 cycle.
- A=-100 (0xFFFFFF9C), B=7 → `data_result`=0xFFFFFFF2 (-14). Then A=-100, B=-7 → 14.
- A=7, B=0 → at latency 34: `data_result`=0, `data_exception`=1.
- A=0x80000000, B=0xFFFFFFFF → `data_result`=0x80000000, `data_exception`=0.
- Start 100/7, re-pulse `ctrl_DIV` with 50/5 at cycle 10 → single RDY at 34 clocks after the second start, result=10. No RDY near cycle 34 of the first op.
- Start 100/7, assert `reset` at cycle 20 → next cycle all outputs 0, `busy`=0. No RDY afterward without a new start.
